// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : MIPS E-stage multiply/divide unit owning the HI/LO registers.
//               Fixed-latency mult/div with busy stall, single-cycle mthi/mtlo.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_mod,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_busy = 1'b1;

    localparam logic [2:0] c_mod_mthi = 3'd4;
    localparam logic [2:0] c_mod_mtlo = 3'd5;

    localparam logic [3:0] c_mul_cnt = 4'(MUL_CYCLES);
    localparam logic [3:0] c_div_cnt = 4'(DIV_CYCLES);

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;

    logic [0:0]  w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic [31:0] w_pend_hi_nxt;
    logic [31:0] w_pend_lo_nxt;

    logic        w_is_md;
    logic        w_is_div;
    logic        w_is_unsigned;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_zero;
    logic [31:0] w_divisor;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_is_md       = start && !mdu_mod[2];
    assign w_is_div      = mdu_mod[1];
    assign w_is_unsigned = mdu_mod[0];

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign w_prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};

    // Signed division through magnitudes; 0x80000000 / -1 wraps to 0x80000000.
    assign w_div_zero = (src_b == 32'd0);
    assign w_divisor  = w_div_zero ? 32'd1 : src_b;
    assign w_abs_a    = src_a[31] ? (32'd0 - src_a) : src_a;
    assign w_abs_b    = w_divisor[31] ? (32'd0 - w_divisor) : w_divisor;
    assign w_sq_mag   = w_abs_a / w_abs_b;
    assign w_sr_mag   = w_abs_a % w_abs_b;
    assign w_sq       = (src_a[31] ^ w_divisor[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr       = src_a[31] ? (32'd0 - w_sr_mag) : w_sr_mag;
    assign w_uq       = src_a / w_divisor;
    assign w_ur       = src_a % w_divisor;

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        if (!w_is_div) begin
            w_res_hi = w_is_unsigned ? w_prod_u[63:32] : w_prod_s[63:32];
            w_res_lo = w_is_unsigned ? w_prod_u[31:0]  : w_prod_s[31:0];
        end else if (!w_div_zero) begin
            w_res_hi = w_is_unsigned ? w_ur : w_sr;
            w_res_lo = w_is_unsigned ? w_uq : w_sq;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        case (r_state)
            c_st_idle: begin
                if (w_is_md) begin
                    w_pend_hi_nxt = w_res_hi;
                    w_pend_lo_nxt = w_res_lo;
                    w_cnt_nxt     = w_is_div ? c_div_cnt : c_mul_cnt;
                    w_state_nxt   = c_st_busy;
                end else if (!start && mdu_mod == c_mod_mthi) begin
                    w_hi_nxt = src_a;
                end else if (!start && mdu_mod == c_mod_mtlo) begin
                    w_lo_nxt = src_a;
                end
            end
            default: begin
                // Any command seen while busy is dropped; only the countdown advances.
                if (r_cnt == 4'd1) begin
                    w_hi_nxt    = r_pend_hi;
                    w_lo_nxt    = r_pend_lo;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = c_st_idle;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
        end
    end

    assign busy = (r_state == c_st_busy);
    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule
`default_nettype wire
